// File: rtl/sar_comparator_nb_pkg.sv
`default_nettype none
// sar_comparator_nb_pkg: state encodings and elaboration helpers shared by the comparator files.
// Revision 1.0
package sar_comparator_nb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EVAL = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  localparam int WAIT_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic bit nvote_ok(input int n);
    return (n >= 1) && ((n % 2) == 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_comparator_nb_if.sv
`default_nettype none
// sar_comparator_nb_if: start/busy/done handshake and DAC code bundle for the comparator.
// Revision 1.0
interface sar_comparator_nb_if #(
  parameter int WIDTH = 10,
  parameter int OFS_W = 4
);
  logic             comp_start;
  logic [WIDTH-1:0] vip;
  logic [WIDTH-1:0] vin;
  logic [OFS_W-1:0] comp_offset;
  logic             comp_busy;
  logic             comp_done;
  logic             comp_result;
  logic             comp_overrun;

  modport master (
    output comp_start, vip, vin, comp_offset,
    input  comp_busy, comp_done, comp_result, comp_overrun
  );

  modport slave (
    input  comp_start, vip, vin, comp_offset,
    output comp_busy, comp_done, comp_result, comp_overrun
  );
endinterface
`default_nettype wire

// File: rtl/sar_comparator_nb_comp_vote_counter.sv
`default_nettype none
// comp_vote_counter: counts vote edges and positive votes; flags the last vote and the majority.
// Revision 1.0
module comp_vote_counter
  import sar_comparator_nb_pkg::*;
#(
  parameter int NVOTE = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear,
  input  wire logic vote_en,
  input  wire logic vote,
  output logic      last_vote,
  output logic      majority
);

  localparam int            CW       = clog2(NVOTE + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NVOTE - 1);
  localparam logic [CW:0]   HALF     = (CW + 1)'(NVOTE / 2);

  logic [CW-1:0] edge_cnt;
  logic [CW-1:0] ones_cnt;
  logic [CW:0]   ones_total;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      edge_cnt <= '0;
      ones_cnt <= '0;
    end else if (vote_en) begin
      edge_cnt <= edge_cnt + 1'b1;
      ones_cnt <= ones_cnt + CW'(vote);
    end
  end

  // The current vote joins the tally combinationally so the decision lands on the last vote edge.
  assign ones_total = {1'b0, ones_cnt} + (CW + 1)'(vote);
  assign last_vote  = vote_en && (edge_cnt == LAST_IDX);
  assign majority   = ones_total > HALF;

endmodule
`default_nettype wire

// File: rtl/sar_comparator_nb.sv
`default_nettype none
// sar_comparator_nb: behavioural SAR comparator with offset, majority voting and programmable latency.
// Revision 1.0
module sar_comparator_nb
  import sar_comparator_nb_pkg::*;
#(
  parameter int WIDTH   = 10,
  parameter int OFS_W   = 4,
  parameter int NVOTE   = 1,
  parameter int LATENCY = 0
) (
  input wire logic          clk,
  input wire logic          rst,
  sar_comparator_nb_if.slave bus
);

  localparam int                CMP_W     = WIDTH + 2;
  localparam bit                NO_WAIT   = (LATENCY == 0);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  if (!nvote_ok(NVOTE)) begin : g_bad_nvote
    $error("sar_comparator_nb: NVOTE must be odd and >= 1");
  end
  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("sar_comparator_nb: LATENCY must be in 0..15");
  end

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              decision;
  logic              busy, done, result, overrun;
  logic              busy_nxt, done_nxt, result_nxt, overrun_nxt;
  logic              accept, wait_last, finish;
  logic              vote, last_vote, majority;

  logic signed [CMP_W-1:0] pos_side;
  logic signed [CMP_W-1:0] neg_side;

  // Two guard bits keep vip+offset free of wrap at both ends of the code range.
  assign pos_side = $signed({2'b00, bus.vip})
                  + $signed({{(CMP_W - OFS_W){bus.comp_offset[OFS_W-1]}}, bus.comp_offset});
  assign neg_side = $signed({2'b00, bus.vin});
  assign vote     = (pos_side >= neg_side);

  comp_vote_counter #(.NVOTE(NVOTE)) u_votes (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .vote_en   (state == ST_EVAL),
    .vote      (vote),
    .last_vote (last_vote),
    .majority  (majority)
  );

  assign accept    = (state == ST_IDLE) && bus.comp_start;
  assign wait_last = (state == ST_WAIT) && (wait_cnt == LAST_WAIT);
  assign finish    = (last_vote && NO_WAIT) || wait_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 1'b0;
      overrun  <= 1'b0;
      wait_cnt <= '0;
      decision <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      result  <= result_nxt;
      overrun <= overrun_nxt;
      // Held at zero outside WAIT, so it is already clear on entry.
      if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                  wait_cnt <= '0;
      if (last_vote) decision <= majority;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.comp_start) state_nxt = ST_EVAL;
      ST_EVAL: if (last_vote) state_nxt = NO_WAIT ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (wait_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_nxt    = (state_nxt != ST_IDLE);
    done_nxt    = finish;
    overrun_nxt = bus.comp_start && busy;
    result_nxt  = result;
    if (accept)      result_nxt = 1'b0;
    else if (finish) result_nxt = NO_WAIT ? majority : decision;
  end

  assign bus.comp_busy    = busy;
  assign bus.comp_done    = done;
  assign bus.comp_result  = result;
  assign bus.comp_overrun = overrun;

endmodule
`default_nettype wire

// File: tb/tb_sar_comparator_nb.sv
`default_nettype none
// tb_sar_comparator_nb: directed checks of several comparator configurations driven from shared stimulus.
// Revision 1.0
module tb_sar_comparator_nb;

  localparam int NCFG = 10;
  localparam int W    = 10;
  localparam int OW   = 4;
  localparam int C0   = 0;   // NVOTE=1, LATENCY=0
  localparam int C9   = 9;   // NVOTE=5, LATENCY=3

  function automatic int cfg_nv(input int i);
    if (i == 9) return 5;
    case (i / 3)
      0:       return 1;
      1:       return 3;
      default: return 7;
    endcase
  endfunction

  function automatic int cfg_lt(input int i);
    if (i == 9) return 3;
    case (i % 3)
      0:       return 0;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  vip, vin;
  logic [OW-1:0] ofs;
  logic [NCFG-1:0] busy_v, done_v, res_v, ovr_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NCFG; i++) begin : g_dut
    sar_comparator_nb_if #(.WIDTH(W), .OFS_W(OW)) ifc ();
    assign ifc.comp_start  = start;
    assign ifc.vip         = vip;
    assign ifc.vin         = vin;
    assign ifc.comp_offset = ofs;
    assign busy_v[i] = ifc.comp_busy;
    assign done_v[i] = ifc.comp_done;
    assign res_v[i]  = ifc.comp_result;
    assign ovr_v[i]  = ifc.comp_overrun;
    sar_comparator_nb #(
      .WIDTH(W), .OFS_W(OW), .NVOTE(cfg_nv(i)), .LATENCY(cfg_lt(i))
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; vip = '0; vin = '0; ofs = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Pulses start for one edge and measures edges until done on one configuration.
  task automatic request(input int cfg, output int lat, output logic res);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    res = 1'bx;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (done_v[cfg]) begin
        lat = t;
        res = res_v[cfg];
        break;
      end
    end
  endtask

  task automatic test_reset();
    int ndone;
    do_reset();
    checks++; if (busy_v !== '0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_v); end
    checks++; if (done_v !== '0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_v); end
    checks++; if (res_v !== '0)  begin errors++; $display("FAIL reset_result: got %b expected 0", res_v); end
    checks++; if (ovr_v !== '0)  begin errors++; $display("FAIL reset_overrun: got %b expected 0", ovr_v); end
    vip = 10'd300; vin = 10'd300; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy_v[C9] !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b expected 1", busy_v[C9]); end
    tick(); tick();
    rst = 1'b1; start = 1'b1;
    tick();
    checks++;
    if ({busy_v[C9], done_v[C9], res_v[C9], ovr_v[C9]} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_eval: got busy/done/res/ovr=%b expected 0000",
               {busy_v[C9], done_v[C9], res_v[C9], ovr_v[C9]});
    end
    checks++; if (busy_v !== '0) begin errors++; $display("FAIL reset_all_busy: got %b expected 0", busy_v); end
    start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    ndone = 0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (done_v !== '0) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL reset_no_done: got %0d expected 0", ndone); end
  endtask

  task automatic test_boundary();
    int   lat;
    logic res;
    do_reset();
    vip = 10'd512; vin = 10'd512; ofs = 4'd0;
    request(C0, lat, res);
    checks++; if (lat !== 1)    begin errors++; $display("FAIL eq_latency: got %0d expected 1", lat); end
    checks++; if (res !== 1'b1) begin errors++; $display("FAIL eq_result: got %b expected 1", res); end
    tick();
    checks++;
    if ({done_v[C0], res_v[C0]} !== 2'b01) begin
      errors++; $display("FAIL result_hold: got done/res=%b expected 01", {done_v[C0], res_v[C0]});
    end
    vip = 10'd511; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy_v[C0], done_v[C0], res_v[C0]} !== 3'b100) begin
      errors++; $display("FAIL accept_clears: got busy/done/res=%b expected 100", {busy_v[C0], done_v[C0], res_v[C0]});
    end
    tick();
    checks++;
    if ({busy_v[C0], done_v[C0], res_v[C0]} !== 3'b010) begin
      errors++; $display("FAIL lt_result: got busy/done/res=%b expected 010", {busy_v[C0], done_v[C0], res_v[C0]});
    end
  endtask

  task automatic test_offset();
    int   lat;
    logic res;
    do_reset();
    vip = 10'd500; vin = 10'd503; ofs = 4'sd3;
    request(C0, lat, res);
    checks++; if (res !== 1'b1) begin errors++; $display("FAIL ofs_p3: got %b expected 1", res); end
    ofs = 4'd2;
    request(C0, lat, res);
    checks++; if (res !== 1'b0) begin errors++; $display("FAIL ofs_p2: got %b expected 0", res); end
    vip = 10'd1023; vin = 10'd1016; ofs = 4'b1000;
    request(C0, lat, res);
    checks++; if (res !== 1'b0) begin errors++; $display("FAIL ofs_m8: got %b expected 0", res); end
    vip = 10'd0; vin = 10'd0; ofs = 4'b1111;
    request(C0, lat, res);
    checks++; if (res !== 1'b0) begin errors++; $display("FAIL ofs_m1_zero: got %b expected 0", res); end
    vip = 10'd1023; vin = 10'd1023; ofs = 4'd7;
    request(C0, lat, res);
    checks++; if (res !== 1'b1) begin errors++; $display("FAIL ofs_p7_top: got %b expected 1", res); end
    checks++; if (lat !== 1)    begin errors++; $display("FAIL ofs_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_voting();
    int   seq [5];
    int   lat;
    logic res;
    do_reset();
    vin = 10'd100; ofs = '0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) seq = '{101, 99, 101, 99, 101};
      else           seq = '{99, 99, 101, 101, 99};
      vip = 10'd50;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = -1;
      res = 1'bx;
      for (int t = 1; t <= 40; t++) begin
        if (t <= 5) vip = W'(seq[t-1]);
        tick();
        if (done_v[C9]) begin lat = t; res = res_v[C9]; break; end
      end
      checks++; if (lat !== 8) begin errors++; $display("FAIL vote_latency%0d: got %0d expected 8", pass, lat); end
      checks++;
      if (res !== (pass == 0 ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL vote_result%0d: got %b expected %b", pass, res, (pass == 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int   ndone, novr;
    logic exp_busy, exp_done, exp_ovr;
    do_reset();
    vip = 10'd200; vin = 10'd200; ofs = '0;
    ndone = 0; novr = 0;
    for (int t = 0; t <= 30; t++) begin
      start = (t == 0) || (t == 2) || (t == 9);
      tick();
      exp_busy = (t < 8) || (t >= 9 && t < 17);
      exp_done = (t == 8) || (t == 17);
      exp_ovr  = (t == 2);
      if (done_v[C9]) ndone++;
      if (ovr_v[C9])  novr++;
      checks++; if (busy_v[C9] !== exp_busy) begin errors++; $display("FAIL b2b_busy t=%0d: got %b expected %b", t, busy_v[C9], exp_busy); end
      checks++; if (done_v[C9] !== exp_done) begin errors++; $display("FAIL b2b_done t=%0d: got %b expected %b", t, done_v[C9], exp_done); end
      checks++; if (ovr_v[C9] !== exp_ovr)   begin errors++; $display("FAIL b2b_overrun t=%0d: got %b expected %b", t, ovr_v[C9], exp_ovr); end
      if (t == 17) begin
        checks++; if (res_v[C9] !== 1'b1) begin errors++; $display("FAIL b2b_result: got %b expected 1", res_v[C9]); end
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", ndone); end
    checks++; if (novr !== 1)  begin errors++; $display("FAIL b2b_overrun_count: got %0d expected 1", novr); end
  endtask

  task automatic test_sweep();
    int   lat_a [NCFG];
    logic res_a [NCFG];
    int   so, d, v;
    logic exp;
    do_reset();
    for (int trial = 0; trial < 30; trial++) begin
      vip = W'($urandom_range(0, 1023));
      d   = int'($urandom_range(0, 40)) - 20;
      v   = int'(vip) + d;
      if (v < 0) v = 0;
      if (v > 1023) v = 1023;
      vin = W'(v);
      ofs = OW'($urandom_range(0, 15));
      so  = ofs[OW-1] ? int'(ofs) - 16 : int'(ofs);
      exp = ((int'(vip) + so) >= int'(vin));
      for (int c = 0; c < NCFG; c++) begin lat_a[c] = -1; res_a[c] = 1'bx; end
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int t = 1; t <= 25; t++) begin
        tick();
        for (int c = 0; c < NCFG; c++) begin
          if (done_v[c] && lat_a[c] < 0) begin lat_a[c] = t; res_a[c] = res_v[c]; end
        end
      end
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (lat_a[c] !== cfg_nv(c) + cfg_lt(c)) begin
          errors++; $display("FAIL sweep_latency cfg=%0d: got %0d expected %0d", c, lat_a[c], cfg_nv(c) + cfg_lt(c));
        end
        checks++;
        if (res_a[c] !== exp) begin
          errors++; $display("FAIL sweep_result cfg=%0d vip=%0d vin=%0d ofs=%0d: got %b expected %b",
                             c, vip, vin, so, res_a[c], exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vip = '0; vin = '0; ofs = '0;
    test_reset();
    test_boundary();
    test_offset();
    test_voting();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
